// File: rtl/vect_stream_unpacker_if.sv
// Handshake bundle for vect_stream_unpacker: a wide vector input stream on one side
// and a scalar lane stream on the other.
`timescale 1ns/1ps

interface vect_stream_unpacker_if #(
  parameter int STREAMW = 32,
  parameter int NLANES  = 16
) ();
  localparam int LW = $clog2(NLANES);

  // Vector side (kernel-top result stream)
  logic                      ivalid;
  logic                      iready;
  logic [NLANES*STREAMW-1:0] vin;

  // Scalar side (store / DMA port)
  logic                      ovalid;
  logic                      oready;
  logic [STREAMW-1:0]        vout;
  logic [LW-1:0]             olane;
  logic                      olast;

  // The unpacker consumes vectors and produces words.
  modport slave (
    input  ivalid, vin, oready,
    output iready, ovalid, vout, olane, olast
  );

  // The surrounding logic produces vectors and consumes words.
  modport master (
    output ivalid, vin, oready,
    input  iready, ovalid, vout, olane, olast
  );
endinterface

// File: rtl/vect_stream_unpacker.sv
// Vector-to-scalar stream unpacker: a 2-entry ring of NLANES-wide vectors drained one
// STREAMW lane per cycle, lane 0 first, with a wrapping count of fully drained vectors.
`timescale 1ns/1ps

module vect_stream_unpacker #(
  parameter int STREAMW = 32,
  parameter int NLANES  = 16,
  parameter int CNTW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  vect_stream_unpacker_if.slave  bus,
  output logic [CNTW-1:0]        vec_cnt
);

  localparam int LW = $clog2(NLANES);
  localparam int VW = NLANES * STREAMW;
  localparam logic [LW-1:0] LAST_LANE = LW'(NLANES - 1);

  // Ring occupancy; doubles as the control state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } occ_e;

  occ_e            state_q, state_d;
  logic [VW-1:0]   entry_q [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [CNTW-1:0] vec_cnt_q, vec_cnt_d;

  logic push;
  logic pop_word;
  logic pop_vec;
  logic at_last;

  // Both handshake qualifiers come from registered state only, so neither ready nor
  // valid has a combinational path from the opposite side.
  assign bus.iready = (state_q != S_FULL);
  assign bus.ovalid = (state_q != S_EMPTY);
  assign bus.vout   = entry_q[rd_ptr_q][STREAMW*int'(lane_q) +: STREAMW];
  assign bus.olane  = lane_q;
  assign bus.olast  = bus.ovalid & at_last;
  assign vec_cnt    = vec_cnt_q;

  assign at_last  = (lane_q == LAST_LANE);
  assign push     = bus.ivalid & bus.iready;
  assign pop_word = bus.ovalid & bus.oready;
  assign pop_vec  = pop_word & at_last;

  // NOTE: every combinational output gets its default before any branch; otherwise a
  // path that skips the assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (push) state_d = S_ONE;
      end
      S_ONE: begin
        if (push && !pop_vec)      state_d = S_FULL;
        else if (pop_vec && !push) state_d = S_EMPTY;
      end
      S_FULL: begin
        // No push can happen while full, so a retiring vector always frees a slot.
        if (pop_vec) state_d = S_ONE;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lane_d    = lane_q;
    vec_cnt_d = vec_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop_word) lane_d = at_last ? '0 : lane_q + 1'b1;
    if (pop_vec) begin
      rd_ptr_d  = ~rd_ptr_q;
      vec_cnt_d = vec_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_EMPTY;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      lane_q    <= '0;
      vec_cnt_q <= '0;
      // NOTE: the two ring entries are reset on purpose: vout reads an entry even while
      // ovalid is low, and it must show zero after reset rather than stale data.
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lane_q    <= lane_d;
      vec_cnt_q <= vec_cnt_d;
      if (push) entry_q[wr_ptr_q] <= bus.vin;
    end
  end

  // Behavioural contract: a stalled word is held, and the lane only moves on a pop.
  a_stall_hold : assert property (@(posedge clk) disable iff (!rst)
    (bus.ovalid && !bus.oready) |=> (bus.ovalid && $stable(bus.vout) && $stable(bus.olane)));

  a_lane_hold : assert property (@(posedge clk) disable iff (!rst)
    !pop_word |=> $stable(lane_q));

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_FULL) |-> !push);

endmodule

// File: tb/tb_vect_stream_unpacker.sv
// Directed bench for vect_stream_unpacker: reset, single vector, back-to-back,
// backpressure, full-with-simultaneous-pop and vec_cnt wrap on a narrow build.
`timescale 1ns/1ps

module tb_vect_stream_unpacker;

  localparam int STREAMW = 32;
  localparam int NLANES  = 16;
  localparam int CNTW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_vec_cnt = 0;

  vect_stream_unpacker_if #(.STREAMW(STREAMW), .NLANES(NLANES)) bus ();
  logic [CNTW-1:0] vec_cnt;

  vect_stream_unpacker #(.STREAMW(STREAMW), .NLANES(NLANES), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .vec_cnt (vec_cnt)
  );

  // Narrow build used for the counter wrap scenario.
  vect_stream_unpacker_if #(.STREAMW(8), .NLANES(2)) bus2 ();
  logic [3:0] vec_cnt2;

  vect_stream_unpacker #(.STREAMW(8), .NLANES(2), .CNTW(4)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2),
    .vec_cnt (vec_cnt2)
  );

  function automatic logic [NLANES*STREAMW-1:0] make_vec(input logic [STREAMW-1:0] base);
    logic [NLANES*STREAMW-1:0] v;
    for (int k = 0; k < NLANES; k++) v[k*STREAMW +: STREAMW] = base + STREAMW'(k);
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.ivalid = 1'b0;  bus.vin = '0;  bus.oready = 1'b0;
    bus2.ivalid = 1'b0; bus2.vin = '0; bus2.oready = 1'b0;
    repeat (2) step();
    checks++;
    if ({bus.ovalid, bus.iready, bus.olast, bus.olane, bus.vout, vec_cnt} !==
        {1'b0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got ovalid=%b iready=%b olast=%b olane=%0d vout=%h vec_cnt=%0d, want 0 1 0 0 0 0",
               bus.ovalid, bus.iready, bus.olast, bus.olane, bus.vout, vec_cnt);
    end
    rst = 1'b1;
    step();
    // Fill both entries, then drain five words of the first.
    bus.ivalid = 1'b1; bus.vin = make_vec(32'h200);
    step();
    bus.vin = make_vec(32'h300);
    step();
    bus.ivalid = 1'b0;
    checks++;
    if (bus.iready !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill_full: got iready=%b, want 0", bus.iready);
    end
    bus.oready = 1'b1;
    repeat (5) step();
    checks++;
    if ({bus.olane, bus.vout} !== {4'd5, 32'h205}) begin
      errors++;
      $display("FAIL reset_mid_drain: got olane=%0d vout=%h, want 5 00000205", bus.olane, bus.vout);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.ovalid, bus.iready, bus.olane, bus.vout, vec_cnt} !==
        {1'b0, 1'b1, 4'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_async: got ovalid=%b iready=%b olane=%0d vout=%h vec_cnt=%0d, want 0 1 0 0 0",
               bus.ovalid, bus.iready, bus.olane, bus.vout, vec_cnt);
    end
    step();
    rst = 1'b1;
    bus.vin = make_vec(32'h200);
    repeat (3) step();
    checks++;
    if ({bus.ovalid, vec_cnt} !== {1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_no_replay: got ovalid=%b vec_cnt=%0d, want 0 0", bus.ovalid, vec_cnt);
    end
    bus.oready = 1'b0;
  endtask

  task automatic test_single;
    bus.ivalid = 1'b1; bus.vin = make_vec(32'h100);
    step();
    bus.ivalid = 1'b0; bus.oready = 1'b1;
    for (int k = 0; k < NLANES; k++) begin
      checks++;
      if ({bus.ovalid, bus.olast, bus.olane, bus.vout} !==
          {1'b1, k == 15, 4'(k), 32'h100 + 32'(k)}) begin
        errors++;
        $display("FAIL single_word%0d: got ovalid=%b olast=%b olane=%0d vout=%h, want 1 %b %0d %h",
                 k, bus.ovalid, bus.olast, bus.olane, bus.vout, k == 15, k, 32'h100 + 32'(k));
      end
      step();
    end
    exp_vec_cnt = 1;
    checks++;
    if ({bus.ovalid, vec_cnt} !== {1'b0, 32'(exp_vec_cnt)}) begin
      errors++;
      $display("FAIL single_done: got ovalid=%b vec_cnt=%0d, want 0 %0d", bus.ovalid, vec_cnt, exp_vec_cnt);
    end
    bus.oready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cnt = 0;
    int nv = 0;
    int w = 0;
    int lo_iready = 0;
    int n_ovalid = 0;
    logic exp_iready, exp_ovalid, drove_valid;
    logic [3:0] exp_lane;
    logic [31:0] exp_word;
    bus.oready = 1'b1;
    for (int c = 0; c < 56; c++) begin
      exp_iready = (cnt != 2);
      exp_ovalid = (cnt != 0);
      exp_lane   = 4'(w % 16);
      exp_word   = 32'h400 + 32'(w / 16) * 32'h100 + 32'(w % 16);
      checks++;
      if ({bus.iready, bus.ovalid} !== {exp_iready, exp_ovalid}) begin
        errors++;
        $display("FAIL b2b_flags c%0d: got iready=%b ovalid=%b, want %b %b",
                 c, bus.iready, bus.ovalid, exp_iready, exp_ovalid);
      end
      if (exp_ovalid) begin
        checks++;
        if ({bus.olast, bus.olane, bus.vout} !== {exp_lane == 4'd15, exp_lane, exp_word}) begin
          errors++;
          $display("FAIL b2b_word c%0d: got olast=%b olane=%0d vout=%h, want %b %0d %h",
                   c, bus.olast, bus.olane, bus.vout, exp_lane == 4'd15, exp_lane, exp_word);
        end
      end
      if (!bus.iready) lo_iready++;
      if (bus.ovalid) n_ovalid++;
      drove_valid = (nv < 3);
      bus.ivalid  = drove_valid;
      bus.vin     = make_vec(32'h400 + 32'(nv) * 32'h100);
      step();
      if (drove_valid && exp_iready) begin
        nv++;
        cnt++;
      end
      if (exp_ovalid && exp_lane == 4'd15) cnt--;
      if (exp_ovalid) w++;
    end
    bus.ivalid = 1'b0;
    bus.oready = 1'b0;
    exp_vec_cnt += 3;
    checks++;
    if (lo_iready !== 30) begin
      errors++;
      $display("FAIL b2b_iready_low_cycles: got %0d, want 30", lo_iready);
    end
    checks++;
    if (n_ovalid !== 48) begin
      errors++;
      $display("FAIL b2b_word_cycles: got %0d, want 48", n_ovalid);
    end
    checks++;
    if (vec_cnt !== 32'(exp_vec_cnt)) begin
      errors++;
      $display("FAIL b2b_vec_cnt: got %0d, want %0d", vec_cnt, exp_vec_cnt);
    end
  endtask

  task automatic test_backpressure;
    bus.oready = 1'b0;
    bus.ivalid = 1'b1; bus.vin = make_vec(32'h700);
    step();
    bus.ivalid = 1'b0;
    // oready alternates 0,1,...: each lane is seen on two consecutive samples.
    for (int i = 0; i < 32; i++) begin
      bus.oready = i[0];
      checks++;
      if ({bus.ovalid, bus.olast, bus.olane, bus.vout} !==
          {1'b1, (i / 2) == 15, 4'(i / 2), 32'h700 + 32'(i / 2)}) begin
        errors++;
        $display("FAIL bp_word i%0d: got ovalid=%b olast=%b olane=%0d vout=%h, want 1 %b %0d %h",
                 i, bus.ovalid, bus.olast, bus.olane, bus.vout, (i / 2) == 15, i / 2, 32'h700 + 32'(i / 2));
      end
      step();
    end
    bus.oready = 1'b0;
    exp_vec_cnt += 1;
    checks++;
    if ({bus.ovalid, vec_cnt} !== {1'b0, 32'(exp_vec_cnt)}) begin
      errors++;
      $display("FAIL bp_done: got ovalid=%b vec_cnt=%0d, want 0 %0d", bus.ovalid, vec_cnt, exp_vec_cnt);
    end
  endtask

  task automatic test_full_simultaneous;
    bus.oready = 1'b0;
    bus.ivalid = 1'b1; bus.vin = make_vec(32'h800);
    step();
    bus.vin = make_vec(32'h900);
    step();
    bus.ivalid = 1'b0; bus.oready = 1'b1;
    repeat (15) step();
    checks++;
    if ({bus.iready, bus.olast, bus.olane, bus.vout} !== {1'b0, 1'b1, 4'd15, 32'h80F}) begin
      errors++;
      $display("FAIL full_at_last: got iready=%b olast=%b olane=%0d vout=%h, want 0 1 15 0000080f",
               bus.iready, bus.olast, bus.olane, bus.vout);
    end
    // Offer a vector in the same cycle the full ring retires one: it must be refused.
    bus.ivalid = 1'b1; bus.vin = make_vec(32'hA00);
    step();
    checks++;
    if ({bus.iready, bus.ovalid, bus.olane, bus.vout} !== {1'b1, 1'b1, 4'd0, 32'h900}) begin
      errors++;
      $display("FAIL full_after_pop: got iready=%b ovalid=%b olane=%0d vout=%h, want 1 1 0 00000900",
               bus.iready, bus.ovalid, bus.olane, bus.vout);
    end
    bus.oready = 1'b0;
    step();
    bus.ivalid = 1'b0;
    checks++;
    if ({bus.iready, bus.olane, bus.vout} !== {1'b0, 4'd0, 32'h900}) begin
      errors++;
      $display("FAIL full_refilled: got iready=%b olane=%0d vout=%h, want 0 0 00000900",
               bus.iready, bus.olane, bus.vout);
    end
    bus.oready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      checks++;
      if ({bus.ovalid, bus.olane, bus.vout} !==
          {1'b1, 4'(j % 16), (j < 16 ? 32'h900 : 32'hA00) + 32'(j % 16)}) begin
        errors++;
        $display("FAIL full_drain j%0d: got ovalid=%b olane=%0d vout=%h, want 1 %0d %h",
                 j, bus.ovalid, bus.olane, bus.vout, j % 16, (j < 16 ? 32'h900 : 32'hA00) + 32'(j % 16));
      end
      step();
    end
    bus.oready = 1'b0;
    exp_vec_cnt += 3;
    checks++;
    if ({bus.ovalid, vec_cnt} !== {1'b0, 32'(exp_vec_cnt)}) begin
      errors++;
      $display("FAIL full_done: got ovalid=%b vec_cnt=%0d, want 0 %0d", bus.ovalid, vec_cnt, exp_vec_cnt);
    end
  endtask

  task automatic test_wrap;
    int pushed = 0;
    int got = 0;
    logic fire_in, fire_out;
    bus2.oready = 1'b1;
    for (int c = 0; c < 200 && got < 34; c++) begin
      bus2.ivalid = (pushed < 17);
      bus2.vin    = {8'(2 * pushed + 1), 8'(2 * pushed)};
      fire_in  = bus2.ivalid && bus2.iready;
      fire_out = bus2.ovalid && bus2.oready;
      if (fire_out) begin
        checks++;
        if (bus2.vout !== 8'(got)) begin
          errors++;
          $display("FAIL wrap_word%0d: got vout=%h, want %h", got, bus2.vout, 8'(got));
        end
        got++;
      end
      step();
      if (fire_in) pushed++;
    end
    bus2.ivalid = 1'b0;
    checks++;
    if (got !== 34) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d words, want 34", got);
    end
    checks++;
    if ({bus2.ovalid, vec_cnt2} !== {1'b0, 4'd1}) begin
      errors++;
      $display("FAIL wrap_vec_cnt: got ovalid=%b vec_cnt=%0d, want 0 1", bus2.ovalid, vec_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_simultaneous();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
